// File: rtl/wire_adc_scan.sv
// rtl/wire_adc_scan.sv - continuous SPI scanner for an 8-ch 12-bit ADC measuring six wires
//
// Drives an ADC128S022-style ADC, cycling through channels 0..NUM_CH-1, and publishes
// S[11:5] of each conversion as a 7-bit wire value (val1 = channel 0 ... val6 = channel 5).
// Optional smoothing filter: define WIRE_ADC_AVG_EN.
//
// Ports:
//   clk, rst_n        system clock, synchronous active-low reset
//   en                scan enable
//   adc_cs_n          ADC chip select (active-low)
//   adc_sclk          SPI clock, idle high
//   adc_din           channel address to the ADC (MOSI)
//   adc_dout          conversion data from the ADC (MISO)
//   val1..val6        latest 7-bit wire values for channels 0..5
//   scan_done         one-clk pulse when val6 updates
module wire_adc_scan #(
    parameter int CLK_DIV = 8,
    parameter int NUM_CH  = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic       adc_cs_n,
    output logic       adc_sclk,
    output logic       adc_din,
    input  logic       adc_dout,
    output logic [6:0] val1,
    output logic [6:0] val2,
    output logic [6:0] val3,
    output logic [6:0] val4,
    output logic [6:0] val5,
    output logic [6:0] val6,
    output logic       scan_done
);

    typedef enum logic [1:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD} state_t;

    localparam logic [8:0] DIV_LAST  = 9'(CLK_DIV - 1);
    localparam logic [8:0] SAMPLE_AT = 9'(CLK_DIV - 2);
    localparam logic [8:0] HOLD_LAST = 9'(2 * CLK_DIV - 1);
    localparam logic [2:0] LAST_CH   = 3'(NUM_CH - 1);

    state_t      state, state_next;
    logic [8:0]  cnt, cnt_next;
    logic [3:0]  bit_idx, bit_next;
    logic        phase, phase_next;   // 0 = SCLK low half, 1 = SCLK high half
    logic [2:0]  addr;                // channel addressed by the current frame
    logic [2:0]  prev_addr;           // channel whose result the current frame returns
    logic        discard;             // current frame's result is stale (first after IDLE)
    logic [6:0]  rx;                  // captures only S[11:5]
    logic [6:0]  vals [0:5];
    logic [15:0] frame_word;
    logic        fall_next;
    logic        sample_now;
    logic        update_now;
`ifdef WIRE_ADC_AVG_EN
    logic [5:0]  primed;
`endif

    assign frame_word = {2'b00, addr, 11'd0};

    // SCLK falls whenever we enter a low half-period of SHIFT
    assign fall_next  = (state_next == SHIFT) && !phase_next && ((state != SHIFT) || phase);
    // One clk before the rising edge, so the capture sees data settled since the fall
    assign sample_now = (state == SHIFT) && !phase && (cnt == SAMPLE_AT)
                        && (bit_idx <= 4'd11) && (bit_idx >= 4'd5);
    // First clk after the 16th rising edge
    assign update_now = (state == SHIFT) && phase && (bit_idx == 4'd0) && (cnt == 9'd0);

    always_comb begin
        state_next = state;
        cnt_next   = cnt + 9'd1;
        bit_next   = bit_idx;
        phase_next = phase;
        case (state)
            IDLE: begin
                cnt_next = 9'd0;
                if (en) state_next = CS_SETUP;
            end
            CS_SETUP: begin
                if (cnt == DIV_LAST) begin
                    state_next = SHIFT;
                    cnt_next   = 9'd0;
                    phase_next = 1'b0;
                    bit_next   = 4'd15;
                end
            end
            SHIFT: begin
                if (cnt == DIV_LAST) begin
                    cnt_next = 9'd0;
                    if (!phase) begin
                        phase_next = 1'b1;
                    end else if (bit_idx == 4'd0) begin
                        state_next = CS_HOLD;
                    end else begin
                        bit_next   = bit_idx - 4'd1;
                        phase_next = 1'b0;
                    end
                end
            end
            CS_HOLD: begin
                if (cnt == HOLD_LAST) begin
                    cnt_next   = 9'd0;
                    state_next = en ? CS_SETUP : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 9'd0;
            bit_idx   <= 4'd0;
            phase     <= 1'b0;
            addr      <= 3'd0;
            prev_addr <= 3'd0;
            discard   <= 1'b1;
            rx        <= 7'd0;
            adc_cs_n  <= 1'b1;
            adc_sclk  <= 1'b1;
            adc_din   <= 1'b0;
            scan_done <= 1'b0;
            for (int i = 0; i < 6; i++) vals[i] <= 7'd0;
`ifdef WIRE_ADC_AVG_EN
            primed    <= 6'd0;
`endif
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            bit_idx   <= bit_next;
            phase     <= phase_next;
            // SPI pins are registered from next-state values so they change glitch-free
            adc_cs_n  <= !((state_next == CS_SETUP) || (state_next == SHIFT));
            adc_sclk  <= !((state_next == SHIFT) && !phase_next);
            if (state_next != SHIFT) adc_din <= 1'b0;
            else if (fall_next)      adc_din <= frame_word[bit_next];
            scan_done <= 1'b0;

            if ((state == IDLE) && en) begin
                addr    <= 3'd0;
                discard <= 1'b1;
            end
            if ((state == CS_HOLD) && (state_next == CS_SETUP)) begin
                prev_addr <= addr;
                addr      <= (addr == LAST_CH) ? 3'd0 : addr + 3'd1;
                discard   <= 1'b0;
            end

            if (sample_now) rx <= {rx[5:0], adc_dout};

            if (update_now && !discard) begin
                for (int i = 0; i < 6; i++) begin
                    if (prev_addr == 3'(i)) begin
`ifdef WIRE_ADC_AVG_EN
                        vals[i]   <= primed[i]
                                     ? 7'(({1'b0, vals[i]} + {1'b0, rx} + 8'd1) >> 1)
                                     : rx;
                        primed[i] <= 1'b1;
`else
                        vals[i] <= rx;
`endif
                    end
                end
                scan_done <= (prev_addr == LAST_CH);
            end
        end
    end

    assign val1 = vals[0];
    assign val2 = vals[1];
    assign val3 = vals[2];
    assign val4 = vals[3];
    assign val5 = vals[4];
    assign val6 = vals[5];

endmodule

// File: tb/tb_wire_adc_scan.sv
// tb/tb_wire_adc_scan.sv - self-checking bench for wire_adc_scan with a behavioural ADC
module tb_wire_adc_scan;

    localparam int CD  = 4;
    localparam int NCH = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       adc_dout = 1'b0;
    logic       adc_cs_n, adc_sclk, adc_din, scan_done;
    logic [6:0] val1, val2, val3, val4, val5, val6;
    logic [6:0] vals [0:5];

    always #5 clk = ~clk;

    wire_adc_scan #(.CLK_DIV(CD), .NUM_CH(NCH)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .adc_din(adc_din), .adc_dout(adc_dout),
        .val1(val1), .val2(val2), .val3(val3), .val4(val4), .val5(val5), .val6(val6),
        .scan_done(scan_done)
    );

    always_comb begin
        vals[0] = val1; vals[1] = val2; vals[2] = val3;
        vals[3] = val4; vals[4] = val5; vals[5] = val6;
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // ---------------- behavioural ADC ----------------
    typedef struct {
        int addr; int zero; int setup; int cslow; int falls; int span;
    } frame_t;

    frame_t      frq[$];
    logic [11:0] chan_val [0:7];
    logic [2:0]  adc_latched = 3'd0;
    logic        prev_cs = 1'b1, prev_sclk = 1'b1;
    logic [15:0] word, rxd;
    int bitpos, rises, nfalls, setup_c, cslow_c, ff_t, lf_t, tick;
    bit seen_fall;
    int frames_started = 0, sclk_edges = 0, done_cnt = 0;

    always @(negedge clk) begin
        frame_t f;
        if (scan_done === 1'b1) done_cnt++;
        if (prev_sclk !== adc_sclk) sclk_edges++;
        if (prev_cs && !adc_cs_n) begin
            frames_started++;
            word = {4'($urandom), chan_val[adc_latched]};
            bitpos = 15; rises = 0; nfalls = 0; setup_c = 0; cslow_c = 0;
            seen_fall = 0; rxd = 16'd0;
        end
        if (!adc_cs_n) begin
            cslow_c++;
            if (!seen_fall && adc_sclk) setup_c++;
        end
        if (!adc_cs_n && prev_sclk && !adc_sclk) begin
            if (nfalls == 0) ff_t = tick;
            lf_t = tick;
            nfalls++;
            seen_fall = 1;
            adc_dout = word[bitpos];
            if (bitpos > 0) bitpos--;
        end
        if (!adc_cs_n && !prev_sclk && adc_sclk) begin
            rxd = {rxd[14:0], adc_din};
            rises++;
        end
        if (!prev_cs && adc_cs_n) begin
            if (rises == 16) begin
                adc_latched = rxd[13:11];
                f.addr  = int'(rxd[13:11]);
                f.zero  = int'({rxd[15:14], rxd[10:0]});
                f.setup = setup_c; f.cslow = cslow_c; f.falls = nfalls; f.span = lf_t - ff_t;
                frq.push_back(f);
            end
            adc_dout = 1'b0;
        end
        prev_cs = adc_cs_n;
        prev_sclk = adc_sclk;
        tick++;
    end

    // ---------------- reference model ----------------
    int exp_val [0:5];
    bit exp_primed [0:5];
    bit first;
    int next_addr, prev_addr, exp_done;

    task automatic model_reset();
        for (int i = 0; i < 6; i++) begin exp_val[i] = 0; exp_primed[i] = 0; end
        first = 1; next_addr = 0; prev_addr = 0;
    endtask

    task automatic set_rand();
        for (int c = 0; c < 8; c++) chan_val[c] = 12'($urandom);
    endtask

    task automatic check_vals(input string tag);
        for (int i = 0; i < 6; i++) check($sformatf("%s_val%0d", tag, i + 1), vals[i], exp_val[i]);
        check($sformatf("%s_done_cnt", tag), done_cnt, exp_done);
    endtask

    task automatic do_frame();
        frame_t r;
        int tgt, s7;
        for (int i = 0; i < 400 && frq.size() == 0; i++) @(negedge clk);
        check("frame_seen", frq.size() > 0, 1);
        if (frq.size() == 0) return;
        r = frq.pop_front();
        check("din_addr", r.addr, next_addr);
        check("din_zero_bits", r.zero, 0);
        check("cs_setup_clks", r.setup, CD);
        check("cs_low_clks", r.cslow, CD + 32 * CD);
        check("sclk_falls", r.falls, 16);
        check("sclk_span", r.span, 15 * 2 * CD);
        if (!first) begin
            tgt = prev_addr;
            s7 = int'(chan_val[tgt] >> 5);
`ifdef WIRE_ADC_AVG_EN
            exp_val[tgt] = exp_primed[tgt] ? (exp_val[tgt] + s7 + 1) / 2 : s7;
            exp_primed[tgt] = 1;
`else
            exp_val[tgt] = s7;
`endif
            if (tgt == NCH - 1) exp_done++;
        end
        first = 0;
        prev_addr = next_addr;
        next_addr = (next_addr + 1) % NCH;
        check_vals("frame");
    endtask

    task automatic wait_start();
        int fs;
        fs = frames_started;
        for (int i = 0; i < 400 && frames_started == fs; i++) @(negedge clk);
        check("frame_start", frames_started != fs, 1);
    endtask

    initial begin
        int fs, edges;
        exp_done = 0;
        model_reset();
        for (int c = 0; c < 8; c++) chan_val[c] = 12'(c * 'h200 + 'h0A0);

        // reset state
        repeat (3) @(negedge clk);
        check("rst_cs_n", adc_cs_n, 1);
        check("rst_sclk", adc_sclk, 1);
        check("rst_din", adc_din, 0);
        check("rst_scan_done", scan_done, 0);
        check_vals("rst");

        // full scan with fixed channel pattern
        rst_n = 1; en = 1;
        repeat (7) do_frame();
        check("scan1_val1", val1, 7'h05);
        check("scan1_val2", val2, 7'h15);
        check("scan1_val3", val3, 7'h25);
        check("scan1_val4", val4, 7'h35);
        check("scan1_val5", val5, 7'h45);
        check("scan1_val6", val6, 7'h55);
        check("scan1_done_once", done_cnt, 1);

        // random samples
        repeat (8) begin set_rand(); do_frame(); end

        // en dropped during bit 8: frame completes, then idle
        wait_start();
        repeat (CD + 7 * 2 * CD + 2) @(negedge clk);
        en = 0;
        do_frame();
        edges = sclk_edges;
        fs = frames_started;
        repeat (60) @(negedge clk);
        check("idle_cs_n", adc_cs_n, 1);
        check("idle_sclk", adc_sclk, 1);
        check("idle_no_sclk_edges", sclk_edges, edges);
        check("idle_no_frames", frames_started, fs);

        // restart begins with a ch0 discard frame
        en = 1; first = 1; next_addr = 0;
        repeat (3) begin set_rand(); do_frame(); end

        // reset during bit 10 of a result-bearing frame
        set_rand();
        wait_start();
        repeat (CD + 5 * 2 * CD + 2) @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        model_reset();
        check("abort_cs_n", adc_cs_n, 1);
        check("abort_sclk", adc_sclk, 1);
        check("abort_din", adc_din, 0);
        check("abort_scan_done", scan_done, 0);
        check_vals("abort");
        repeat (2) @(negedge clk);
        check("abort_no_frame", frq.size(), 0);

        // recovery scan after reset
        rst_n = 1;
        repeat (7) begin set_rand(); do_frame(); end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
